// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: owns the PC, reads the ROM combinationally
// and queues {pc, inst} pairs for decode; redirects flush the queue.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          ROM_AW   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [31:0]              rom_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          push;
    logic [31:0]   pc_rd   [DEPTH];
    logic [31:0]   inst_rd [DEPTH];
    logic          unused_lsbs;

    // Target word alignment drops the low bits of the redirect PC.
    assign unused_lsbs = ^redirect_pc[1:0];

    assign rom_addr   = fetch_pc[ROM_AW-1:0];
    assign out_valid  = (count != '0);
    assign fifo_count = count;
    assign out_pc     = pc_rd[rd_ptr];
    assign out_inst   = inst_rd[rd_ptr];

    // Handshake qualifiers; a redirect suppresses both push and pop.
    always_comb begin
        pop  = out_valid && out_ready && !redirect_valid;
        push = fetch_en && !redirect_valid && ((count < FULL) || pop);
    end

    // PC, pointers and occupancy; redirect wins over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        logic [31:0] pc_q;
        logic [31:0] inst_q;

        assign pc_rd[i]   = pc_q;
        assign inst_rd[i] = inst_q;

        if (i == 0) begin : g_head
            // Entry 0 is the head after reset, so it resets to {0, NOP}.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_q   <= '0;
                    inst_q <= NOP;
                end else if (push && (wr_ptr == PW'(i))) begin
                    pc_q   <= fetch_pc;
                    inst_q <= rom_inst;
                end
            end
        end else begin : g_body
            // Other entries only matter once count covers them.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr == PW'(i))) begin
                    pc_q   <= fetch_pc;
                    inst_q <= rom_inst;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: queue-based reference model,
// directed scenarios followed by randomized fetch/redirect/stall traffic.
module tb_ifetch_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          ROM_AW   = 12;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [31:0]       out_pc;
    logic [2:0]        fifo_count;

    entry_t      exp_q[$];
    logic [31:0] mpc;
    int          n_checks = 0;
    int          n_pass   = 0;

    ifetch_prefetch #(
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH),
        .ROM_AW(ROM_AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // ROM: word i holds 0x1000_0000 + i
    assign rom_inst = 32'h1000_0000 + {22'd0, rom_addr[11:2]};

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] widx;
        widx = (pc % 32'd4096) / 32'd4;
        return 32'h1000_0000 + widx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Reference model for one rising edge, using the inputs now applied.
    // Pops are retired by the monitor before this edge.
    task automatic model_edge();
        entry_t e;
        if (reset) return;
        if (redirect_valid) begin
            exp_q.delete();
            mpc = redirect_pc & 32'hFFFF_FFFC;
        end else if (fetch_en && exp_q.size() < DEPTH) begin
            e.pc   = mpc;
            e.inst = rom_word(mpc);
            exp_q.push_back(e);
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic cycle(input bit fe, input bit rv,
                         input logic [31:0] rpc, input bit rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: checks status every cycle and retires accepted heads.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
            chk("rom_addr", 32'(rom_addr), mpc % 32'd4096);
            if (out_valid && out_ready && !redirect_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        mpc            = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_inst", out_inst, NOP);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), RESET_PC % 32'd4096);
        reset = 1'b0;

        // backpressure from reset: fills to 4, head held
        repeat (10) cycle(1, 0, 0, 0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_fetch_pc", 32'(rom_addr), 32'h10);
        chk("full_head_pc", out_pc, 32'h0);
        chk("full_head_inst", out_inst, 32'h1000_0000);

        // release: full with ready high keeps count at 4
        repeat (6) begin
            cycle(1, 0, 0, 1);
            chk("pushpop_count", 32'(fifo_count), 32'd4);
        end

        // drain, then queue three entries
        repeat (6) cycle(0, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0);
        chk("pre_redir_count", 32'(fifo_count), 32'd3);
        cycle(1, 1, 32'h0000_0042, 1);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h40);
        cycle(1, 0, 0, 1);
        chk("redir_head_pc", out_pc, 32'h40);
        chk("redir_head_inst", out_inst, 32'h1000_0010);
        repeat (4) cycle(1, 0, 0, 1);

        // fetch_en low: drain and hold PC
        repeat (5) cycle(0, 0, 0, 1);
        chk("drain_count", 32'(fifo_count), 32'd0);
        repeat (4) cycle(1, 0, 0, 1);

        // wrap at top of address space
        cycle(1, 1, 32'hFFFF_FFFC, 1);
        repeat (5) cycle(1, 0, 0, 1);

        // asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_count", 32'(fifo_count), 32'd0);
        chk("areset_pc", out_pc, 32'd0);
        exp_q.delete();
        mpc = RESET_PC;
        repeat (2) cycle(1, 0, 0, 1);
        reset = 1'b0;
        repeat (5) cycle(1, 0, 0, 1);

        // randomized traffic
        repeat (500) begin
            logic [31:0] rpc;
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                  rpc, $urandom_range(0, 2) != 0);
        end
        repeat (8) cycle(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
